// File: rtl/pe_accum_requant.sv
// rtl/pe_accum_requant.sv - accumulate PE products plus bias, requantize to signed DATA_WIDTH with saturation
// Optional ReLU before the output clamp is enabled by defining PE_ACC_RELU_EN.
module pe_accum_requant #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MULT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [2*DATA_WIDTH-1:0] in_prod,
    input  logic                         in_last,
    input  logic signed [ACC_WIDTH-1:0]  cfg_bias,
    input  logic [MULT_WIDTH-1:0]        cfg_mult,
    input  logic [4:0]                   cfg_shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_sat,
    output logic                         busy
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = ACC_WIDTH + MULT_WIDTH + 1;
    localparam int RW = SW + 1;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [RW-1:0]        OUT_MAX = RW'(2 ** (DATA_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0]        OUT_MIN = ~OUT_MAX;

    typedef enum logic [2:0] {IDLE, ACCUM, SCALE, ROUND, OUT} state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [MULT_WIDTH-1:0]         mult_q, mult_d;
    logic [4:0]                    shift_q, shift_d;
    logic signed [SW-1:0]          scaled_q, scaled_d;
    logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;

    logic                          beat_acc;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [SW-1:0]          acc_ext, mult_ext;
    logic signed [RW-1:0]          round_inc, round_sum, round_r, relu_r, clamp_v;
    logic                          clip;

    // Two's-complement add that pins to the rails instead of wrapping.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0]          s;
        logic signed [ACC_WIDTH-1:0] res;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            res = s[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            res = s[ACC_WIDTH-1:0];
        end
        return res;
    endfunction

    assign beat_acc = in_valid && in_ready;
    assign prod_ext = {{(ACC_WIDTH-PW){in_prod[PW-1]}}, in_prod};
    assign acc_ext  = {{(SW-ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q};
    assign mult_ext = {{(SW-MULT_WIDTH){1'b0}}, mult_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: if (beat_acc) state_d = in_last ? SCALE : ACCUM;
            SCALE:       state_d = ROUND;
            ROUND:       state_d = OUT;
            OUT:         if (out_ready) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || (state_q == ACCUM);
        out_valid = (state_q == OUT);
        busy      = (state_q != IDLE);
        out_data  = out_data_q;
        out_sat   = out_sat_q;
    end

    // Round half toward +inf, optional ReLU, then clamp to the output range.
    always_comb begin
        round_inc = (shift_q == 5'd0) ? '0 : (RW'(1) << (shift_q - 5'd1));
        round_sum = {scaled_q[SW-1], scaled_q} + round_inc;
        round_r   = round_sum >>> shift_q;
`ifdef PE_ACC_RELU_EN
        relu_r    = round_r[RW-1] ? '0 : round_r;
`else
        relu_r    = round_r;
`endif
        clip      = 1'b0;
        clamp_v   = relu_r;
        if (relu_r > OUT_MAX) begin
            clamp_v = OUT_MAX;
            clip    = 1'b1;
        end else if (relu_r < OUT_MIN) begin
            clamp_v = OUT_MIN;
            clip    = 1'b1;
        end
    end

    always_comb begin
        acc_d      = acc_q;
        mult_d     = mult_q;
        shift_d    = shift_q;
        scaled_d   = scaled_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: begin
                if (beat_acc) begin
                    acc_d   = sat_add(cfg_bias, prod_ext);
                    mult_d  = cfg_mult;
                    shift_d = cfg_shift;
                end
            end
            ACCUM: begin
                if (beat_acc) acc_d = sat_add(acc_q, prod_ext);
            end
            SCALE: scaled_d = acc_ext * mult_ext;
            ROUND: begin
                out_data_d = clamp_v[DATA_WIDTH-1:0];
                out_sat_d  = clip;
            end
            OUT: begin
                if (out_ready) acc_d = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            mult_q     <= '0;
            shift_q    <= '0;
            scaled_q   <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mult_q     <= mult_d;
            shift_q    <= shift_d;
            scaled_q   <= scaled_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_pe_accum_requant.sv
// tb/tb_pe_accum_requant.sv - randomized self-checking bench for pe_accum_requant against an arithmetic model
module tb_pe_accum_requant;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic        in_last;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    pe_accum_requant #(.DATA_WIDTH(8), .ACC_WIDTH(32), .MULT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last),
        .cfg_bias(cfg_bias), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int model(input int beats[$], input int bias, input int mult,
                                 input int shift, output bit sat);
        longint acc, scaled, r;
        acc = longint'(bias);
        foreach (beats[i]) begin
            acc = acc + longint'(beats[i]);
            if (acc > 64'sd2147483647) acc = 64'sd2147483647;
            if (acc < -64'sd2147483648) acc = -64'sd2147483648;
        end
        scaled = acc * longint'(mult);
        if (shift > 0) r = (scaled + (longint'(1) <<< (shift - 1))) >>> shift;
        else           r = scaled;
`ifdef PE_ACC_RELU_EN
        if (r < 0) r = 0;
`endif
        sat = 1'b0;
        if (r > 127)  begin r = 127;  sat = 1'b1; end
        if (r < -128) begin r = -128; sat = 1'b1; end
        return int'(r);
    endfunction

    // Drives one vector, measures negedges until out_valid, and completes the output handshake.
    task automatic run_vector(input int beats[$], input int bias, input int mult, input int shift,
                              input bit rand_ready, output int data, output bit sat, output int lat);
        int n;
        int guard;
        n = beats.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_prod  = 16'(beats[i]);
            in_last  = (i == n - 1);
            if (i == 0) begin
                cfg_bias = bias; cfg_mult = 16'(mult); cfg_shift = 5'(shift);
            end else begin
                cfg_bias = $urandom; cfg_mult = 16'($urandom); cfg_shift = 5'($urandom);
            end
            guard = 0;
            while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; in_prod = 16'($urandom);
        if (!rand_ready) out_ready = 1'b1;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        guard = 0;
        while (guard < 50) begin
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) break;
            @(negedge clk);
            guard++;
        end
        data = int'($signed(out_data));
        sat  = out_sat;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
        cfg_bias = '0; cfg_mult = '0; cfg_shift = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'd0)  begin failures++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
        checks++; if (out_sat !== 1'b0)   begin failures++; $display("FAIL reset_out_sat got=%b exp=0", out_sat); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        int q[$]; int d; bit s; int lat;
        int exp_d[6]; bit exp_s[6];
        int bias[6]; int mult[6]; int shift[6];
        exp_d = '{60, 8, -1, 127, -128, 7};
        exp_s = '{0, 0, 0, 1, 1, 0};
        bias  = '{0, 5, 0, 0, 0, -3};
        mult  = '{1, 3, 1, 1, 1, 1};
        shift = '{0, 2, 2, 0, 0, 0};
        for (int t = 0; t < 6; t++) begin
            case (t)
                0: q = '{10, 20, 30};
                1: q = '{6};
                2: q = '{-6};
                3: q = '{16129, 16129};
                4: q = '{-16384, -16384};
                default: q = '{4, 6};
            endcase
            run_vector(q, bias[t], mult[t], shift[t], 1'b0, d, s, lat);
            checks++; if (d !== exp_d[t]) begin failures++; $display("FAIL directed_data[%0d] got=%0d exp=%0d", t, d, exp_d[t]); end
            checks++; if (s !== exp_s[t]) begin failures++; $display("FAIL directed_sat[%0d] got=%b exp=%b", t, s, exp_s[t]); end
            checks++; if (lat !== 3)      begin failures++; $display("FAIL directed_latency[%0d] got=%0d exp=3", t, lat); end
        end
    endtask

    task automatic test_backpressure;
        int q[$]; int d; bit s; int lat; int guard;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_prod = 16'd3; in_last = 1'b0;
        cfg_bias = '0; cfg_mult = 16'd1; cfg_shift = 5'd0;
        @(posedge clk);
        @(negedge clk);
        in_prod = 16'd4; in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); guard++; end
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; in_prod = 16'd99; in_last = 1'b1;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", c, out_valid); end
            checks++; if (out_data !== 8'd7)  begin failures++; $display("FAIL stall_data[%0d] got=%0d exp=7", c, out_data); end
            checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL stall_in_ready[%0d] got=%b exp=0", c, in_ready); end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_release_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL stall_release_busy got=%b exp=0", busy); end
        checks++; if (out_data !== 8'd7)  begin failures++; $display("FAIL stall_retain_data got=%0d exp=7", out_data); end
        q = '{1};
        run_vector(q, 0, 1, 0, 1'b0, d, s, lat);
        checks++; if (d !== 1) begin failures++; $display("FAIL stall_next_data got=%0d exp=1", d); end
    endtask

    task automatic test_reset_mid;
        int q[$]; int d; bit s; int lat;
        @(negedge clk);
        in_valid = 1'b1; in_prod = 16'd100; in_last = 1'b0;
        cfg_bias = 32'd1000; cfg_mult = 16'd1; cfg_shift = 5'd0;
        @(posedge clk);
        @(negedge clk);
        in_prod = 16'd200;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_data !== 8'd0) begin failures++; $display("FAIL midrst_out_data got=%0d exp=0", out_data); end
        @(negedge clk);
        rst = 1'b0;
        q = '{7};
        run_vector(q, 0, 1, 0, 1'b0, d, s, lat);
        checks++; if (d !== 7)   begin failures++; $display("FAIL midrst_data got=%0d exp=7", d); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL midrst_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_relu;
        int q[$]; int d; bit s; int lat; int exp_d;
`ifdef PE_ACC_RELU_EN
        exp_d = 0;
`else
        exp_d = -50;
`endif
        q = '{-50};
        run_vector(q, 0, 1, 0, 1'b0, d, s, lat);
        checks++; if (d !== exp_d) begin failures++; $display("FAIL relu_data got=%0d exp=%0d", d, exp_d); end
        checks++; if (s !== 1'b0)  begin failures++; $display("FAIL relu_sat got=%b exp=0", s); end
    endtask

    task automatic test_back_to_back;
        int q[$]; int d; bit s; int lat;
        q = '{12, -2};
        run_vector(q, 0, 1, 0, 1'b0, d, s, lat);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        q = '{-9};
        run_vector(q, 1, 1, 0, 1'b0, d, s, lat);
        checks++; if (d !== -8)  begin failures++; $display("FAIL b2b_data got=%0d exp=-8", d); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    endtask

    task automatic test_random;
        int q[$]; int d; bit s; int lat; int exp_d; bit exp_s;
        int len; int bias; int mult; int shift;
        for (int v = 0; v < 40; v++) begin
            q.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) q.push_back(int'($signed(16'($urandom))));
            case ($urandom_range(0, 3))
                0: bias = 0;
                1: bias = int'($urandom_range(0, 2000)) - 1000;
                2: bias = int'($urandom);
                default: bias = ($urandom_range(0, 1) != 0) ? 32'sh7fff_fff0 : 32'sh8000_0010;
            endcase
            mult  = $urandom_range(0, 65535);
            shift = $urandom_range(0, 31);
            exp_d = model(q, bias, mult, shift, exp_s);
            run_vector(q, bias, mult, shift, 1'b1, d, s, lat);
            checks++; if (d !== exp_d) begin failures++; $display("FAIL rand_data[%0d] got=%0d exp=%0d", v, d, exp_d); end
            checks++; if (s !== exp_s) begin failures++; $display("FAIL rand_sat[%0d] got=%b exp=%b", v, s, exp_s); end
            checks++; if (lat !== 3)   begin failures++; $display("FAIL rand_latency[%0d] got=%0d exp=3", v, lat); end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_relu();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
